// File: rtl/div_int32_seq_pkg.sv
// div_int32_seq_pkg: shared state encoding and sizing helpers for the sequential divider
package div_int32_seq_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int DEF_WIDTH = 32;

    // Iteration counter width for a given operand width (at least one bit)
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_bits(DEF_WIDTH);

endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: N-bit ripple adder with carry in/out
module adder_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/div_int32_seq_step.sv
// div_step: one combinational restoring-division step on a shared subtractor
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic           cout;

    adder_nbit #(.N(WIDTH + 1)) u_sub (
        .a    ({rem, dvd_bit}),
        .b    (~{1'b0, divisor}),
        .cin  (1'b1),
        .sum  (trial),
        .cout (cout)
    );

    // No borrow means the trial is non-negative; its top bit is then always clear
    assign q_bit    = cout && !trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd_bit};

endmodule

// File: rtl/div_int32_seq.sv
// div_int32_seq: iterative restoring divider, one quotient bit per cycle, valid/ready on both sides
module div_int32_seq
    import div_int32_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int               CW       = cnt_bits(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, dvd, dsr, mag_a, mag_b, rem_nx, q_raw;
    logic             neg_q, neg_r, sa, sb, ovf, special, accept, q_bit;

    assign sa      = SIGNED && A[WIDTH-1];
    assign sb      = SIGNED && B[WIDTH-1];
    assign mag_a   = sa ? -A : A;
    assign mag_b   = sb ? -B : B;
    assign ovf     = SIGNED && (A == MOST_NEG) && (B == '1);
    assign special = (B == '0) || ovf;
    assign accept  = in_valid && (state == IDLE);
    // dvd shifts the dividend out at the top while quotient bits enter at the bottom
    assign q_raw   = {dvd[WIDTH-2:0], q_bit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[WIDTH-1]),
        .divisor  (dsr),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = special ? DONE : BUSY;
            end
            BUSY: if (cnt == '0) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and final sign fixup
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= CNT_LAST;
            rem         <= '0;
            dvd         <= mag_a;
            dsr         <= mag_b;
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            div_by_zero <= (B == '0);
            if (B == '0) begin
                Q <= '1;
                R <= A;
            end else if (ovf) begin
                Q <= A;
                R <= '0;
            end
        end else if (state == BUSY) begin
            rem <= rem_nx;
            dvd <= q_raw;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                Q <= neg_q ? -q_raw : q_raw;
                R <= neg_r ? -rem_nx : rem_nx;
            end
        end
    end

endmodule
